// File: rtl/image_link_pkg.sv
// Constants and types shared by both ends of the camera-image UART link.
// Both the sender and the receiver import this so the wire format cannot drift.
package image_link_pkg;

    localparam logic [11:0] START_WORD             = 12'h00A;
    localparam int          DEFAULT_NUM_PIXELS     = 76800;
    localparam int          DEFAULT_BAUD_RATE      = 115200;
    localparam int          DEFAULT_CLK_FREQ       = 50_000_000;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 250_000;
    localparam int          ADDR_W                 = 17;

    typedef logic [11:0]       pixel_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        HUNT,
        PIX_HI,
        PIX_LO
    } rx_state_t;

    // Each 12-bit word travels high byte first; the high byte carries only the top nibble.
    function automatic logic [7:0] word_hi_byte(input pixel_t w);
        return {4'h0, w[11:8]};
    endfunction

    function automatic logic [7:0] word_lo_byte(input pixel_t w);
        return w[7:0];
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, start-glitch rejection.
// Latency: rx_valid/rx_ferr one cycle after the mid-stop-bit sample; no backpressure.
// Backpressure: none, the consumer must take every rx_valid pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int             CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_state_t;

    uart_state_t      state, state_nxt;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [7:0]       data_nxt;
    logic             valid_nxt;
    logic             ferr_nxt;

    assign rx_s = sync_q[1];

    // Synchroniser resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], rx};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shreg    <= shreg_nxt;
            rx_data  <= data_nxt;
            rx_valid <= valid_nxt;
            rx_ferr  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        data_nxt    = rx_data;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_nxt = RX_START;
                    cnt_nxt   = '0;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = RX_STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = RX_IDLE;
                    if (rx_s) begin
                        valid_nxt = 1'b1;
                        data_nxt  = shreg;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/image_receiver.sv
// UART image receiver: hunts for the start word, reassembles 12-bit pixels, strobes frame-buffer writes.
// Latency: write/done strobes one cycle after the low byte's rx_valid; frame_error one cycle after the cause.
// Backpressure: none, the frame buffer must accept every wr_en cycle.
module image_receiver
    import image_link_pkg::*;
#(
    parameter int CLK_FREQ       = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE      = DEFAULT_BAUD_RATE,
    parameter int NUM_PIXELS     = DEFAULT_NUM_PIXELS,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_address,
    output logic [11:0]       wr_data,
    output logic              frame_done,
    output logic              frame_error,
    output logic              busy
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int          TO_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam addr_t       LAST_ADDR    = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [7:0]  START_HI     = word_hi_byte(START_WORD);
    localparam logic [7:0]  START_LO     = word_lo_byte(START_WORD);

    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ferr;

    rx_state_t       state, state_nxt;
    addr_t           pix_cnt, pix_cnt_nxt;
    logic [3:0]      nibble, nibble_nxt;
    logic            hunt_hi, hunt_hi_nxt;
    logic [TO_W-1:0] idle_cnt, idle_cnt_nxt;
    logic            abort;
    logic            wr_en_nxt;
    addr_t           wr_address_nxt;
    pixel_t          wr_data_nxt;
    logic            frame_done_nxt;
    logic            frame_error_nxt;
    logic            busy_nxt;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (uart_in),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            pix_cnt     <= '0;
            nibble      <= '0;
            hunt_hi     <= 1'b0;
            idle_cnt    <= '0;
            wr_en       <= 1'b0;
            wr_address  <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pix_cnt     <= pix_cnt_nxt;
            nibble      <= nibble_nxt;
            hunt_hi     <= hunt_hi_nxt;
            idle_cnt    <= idle_cnt_nxt;
            wr_en       <= wr_en_nxt;
            wr_address  <= wr_address_nxt;
            wr_data     <= wr_data_nxt;
            frame_done  <= frame_done_nxt;
            frame_error <= frame_error_nxt;
            busy        <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pix_cnt_nxt     = pix_cnt;
        nibble_nxt      = nibble;
        hunt_hi_nxt     = hunt_hi;
        idle_cnt_nxt    = idle_cnt;
        abort           = 1'b0;
        wr_en_nxt       = 1'b0;
        wr_address_nxt  = wr_address;
        wr_data_nxt     = wr_data;
        frame_done_nxt  = 1'b0;
        frame_error_nxt = 1'b0;
        busy_nxt        = busy;

        // Idle timer only runs inside a frame; any received byte restarts it.
        if (state != HUNT) begin
            if (rx_valid) begin
                idle_cnt_nxt = '0;
            end else if (idle_cnt == TO_LAST) begin
                abort = 1'b1;
            end else begin
                idle_cnt_nxt = idle_cnt + 1'b1;
            end
        end

        case (state)
            HUNT: begin
                idle_cnt_nxt = '0;
                if (rx_ferr) begin
                    hunt_hi_nxt = 1'b0;
                end else if (rx_valid) begin
                    if (hunt_hi && rx_data == START_LO) begin
                        state_nxt   = PIX_HI;
                        pix_cnt_nxt = '0;
                        busy_nxt    = 1'b1;
                        hunt_hi_nxt = 1'b0;
                    end else begin
                        hunt_hi_nxt = (rx_data == START_HI);
                    end
                end
            end
            PIX_HI: begin
                if (rx_ferr) begin
                    abort = 1'b1;
                end else if (rx_valid) begin
                    if (rx_data[7:4] != 4'h0) begin
                        abort = 1'b1;
                    end else begin
                        nibble_nxt = rx_data[3:0];
                        state_nxt  = PIX_LO;
                    end
                end
            end
            PIX_LO: begin
                if (rx_ferr) begin
                    abort = 1'b1;
                end else if (rx_valid) begin
                    wr_en_nxt      = 1'b1;
                    wr_address_nxt = pix_cnt;
                    wr_data_nxt    = {nibble, rx_data};
                    if (pix_cnt == LAST_ADDR) begin
                        frame_done_nxt = 1'b1;
                        busy_nxt       = 1'b0;
                        state_nxt      = HUNT;
                    end else begin
                        pix_cnt_nxt = pix_cnt + 1'b1;
                        state_nxt   = PIX_HI;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase

        // Abort keeps already-written pixels; it only ends the frame.
        if (abort) begin
            state_nxt       = HUNT;
            frame_error_nxt = 1'b1;
            busy_nxt        = 1'b0;
            idle_cnt_nxt    = '0;
            hunt_hi_nxt     = 1'b0;
        end
    end

endmodule

// File: tb/tb_image_receiver.sv
// Randomised bench for image_receiver against a byte-stream reference model.
// Small geometry: 8 clocks per bit, 4-pixel frames, 400-clock idle timeout.
module tb_image_receiver;
    import image_link_pkg::*;

    localparam int CPB     = 8;
    localparam int NUM     = 4;
    localparam int TIMEOUT = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_in = 1'b1;
    logic        wr_en;
    logic [16:0] wr_address;
    logic [11:0] wr_data;
    logic        frame_done;
    logic        frame_error;
    logic        busy;

    image_receiver #(
        .CLK_FREQ      (800),
        .BAUD_RATE     (100),
        .NUM_PIXELS    (NUM),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_in    (uart_in),
        .wr_en      (wr_en),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  tx_q[$];
    bit          ferr_q[$];
    logic [28:0] exp_wr[$];
    logic [28:0] obs_wr[$];
    int          exp_done, exp_err;
    bit          exp_busy;
    int          n_done, n_err, n_bad, n_rxv;

    // Observer: records writes and pulses while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) obs_wr.push_back({wr_address, wr_data});
            if (frame_done) n_done++;
            if (frame_error) n_err++;
            if (frame_done && (!wr_en || busy)) n_bad++;
            if (frame_error && busy) n_bad++;
            if (dut.u_rx.rx_valid || dut.u_rx.rx_ferr) n_rxv++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic clear_all();
        obs_wr.delete();
        tx_q.delete();
        ferr_q.delete();
        n_done = 0;
        n_err  = 0;
        n_bad  = 0;
        n_rxv  = 0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit bad_stop);
        tx_q.push_back(b);
        ferr_q.push_back(bad_stop);
    endtask

    task automatic push_pixel(input logic [11:0] p);
        push_byte({4'h0, p[11:8]}, 1'b0);
        push_byte(p[7:0], 1'b0);
    endtask

    // Reference model: interprets the byte stream by the link rules, from HUNT.
    task automatic run_model();
        bit hunting = 1'b1;
        bit prev0 = 1'b0;
        int p = 0;
        int i = 0;
        exp_wr.delete();
        exp_done = 0;
        exp_err  = 0;
        while (i < tx_q.size()) begin
            if (hunting) begin
                if (ferr_q[i]) prev0 = 1'b0;
                else if (prev0 && tx_q[i] == 8'h0A) begin
                    hunting = 1'b0;
                    p = 0;
                    prev0 = 1'b0;
                end else prev0 = (tx_q[i] == 8'h00);
                i++;
            end else if (ferr_q[i] || tx_q[i][7:4] != 4'h0) begin
                exp_err++;
                hunting = 1'b1;
                i++;
            end else if (i + 1 >= tx_q.size()) begin
                i++;
            end else if (ferr_q[i+1]) begin
                exp_err++;
                hunting = 1'b1;
                i += 2;
            end else begin
                exp_wr.push_back({17'(p), tx_q[i][3:0], tx_q[i+1]});
                p++;
                i += 2;
                if (p == NUM) begin
                    exp_done++;
                    hunting = 1'b1;
                end
            end
        end
        exp_busy = !hunting;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            uart_in = b[k];
            repeat (CPB) @(negedge clk);
        end
        uart_in = stop;
        repeat (CPB) @(negedge clk);
        uart_in = 1'b1;
    endtask

    task automatic send_range(input int lo, input int hi, input int max_gap);
        for (int i = lo; i < hi; i++) begin
            send_byte(tx_q[i], !ferr_q[i]);
            if (ferr_q[i]) repeat (2 * CPB) @(negedge clk);
            else repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++;
        if ({wr_en, wr_address, wr_data, frame_done, frame_error, busy} !== 33'd0)
            $display("FAIL reset_outputs got %h want 0", {wr_en, wr_address, wr_data, frame_done, frame_error, busy});
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_total++;
        if ({wr_en, wr_address, wr_data, frame_done, frame_error, busy} !== 33'd0)
            $display("FAIL post_reset_outputs got %h want 0", {wr_en, wr_address, wr_data, frame_done, frame_error, busy});
        else n_pass++;
    endtask

    task automatic test_nominal();
        clear_all();
        push_byte(8'h00, 0); push_byte(8'h0A, 0);
        push_pixel(12'hFFF); push_pixel(12'h123); push_pixel(12'hABC); push_pixel(12'h000);
        run_model();
        send_range(0, 2, 6);
        n_total++;
        if (busy !== 1'b1) $display("FAIL nominal_busy_after_start got %b want 1", busy);
        else n_pass++;
        send_range(2, tx_q.size(), 6);
        n_total++;
        if (obs_wr.size() !== exp_wr.size()) $display("FAIL nominal_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size());
        else n_pass++;
        foreach (exp_wr[k]) if (k < obs_wr.size()) begin
            n_total++;
            if (obs_wr[k] !== exp_wr[k]) $display("FAIL nominal_wr%0d got %h want %h", k, obs_wr[k], exp_wr[k]);
            else n_pass++;
        end
        n_total++;
        if (n_done !== exp_done || n_err !== exp_err || busy !== exp_busy || n_bad !== 0)
            $display("FAIL nominal_status got done=%0d err=%0d busy=%b bad=%0d want done=%0d err=%0d busy=%b bad=0",
                     n_done, n_err, busy, n_bad, exp_done, exp_err, exp_busy);
        else n_pass++;
    endtask

    task automatic test_leading_garbage();
        clear_all();
        push_byte(8'h55, 0); push_byte(8'h00, 0); push_byte(8'h12, 0);
        push_byte(8'h00, 0); push_byte(8'h0A, 0);
        for (int k = 0; k < NUM; k++) push_pixel(12'($urandom));
        run_model();
        send_range(0, 5, 10);
        n_total++;
        if (obs_wr.size() !== 0) $display("FAIL garbage_no_early_write got %0d want 0", obs_wr.size());
        else n_pass++;
        send_range(5, tx_q.size(), 10);
        n_total++;
        if (obs_wr.size() !== exp_wr.size()) $display("FAIL garbage_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size());
        else n_pass++;
        foreach (exp_wr[k]) if (k < obs_wr.size()) begin
            n_total++;
            if (obs_wr[k] !== exp_wr[k]) $display("FAIL garbage_wr%0d got %h want %h", k, obs_wr[k], exp_wr[k]);
            else n_pass++;
        end
        n_total++;
        if (n_done !== exp_done || n_err !== exp_err || busy !== exp_busy || n_bad !== 0)
            $display("FAIL garbage_status got done=%0d err=%0d busy=%b want done=%0d err=%0d busy=%b",
                     n_done, n_err, busy, exp_done, exp_err, exp_busy);
        else n_pass++;
    endtask

    task automatic test_framing_error();
        logic [11:0] p1;
        clear_all();
        p1 = 12'($urandom);
        push_byte(8'h00, 0); push_byte(8'h0A, 0);
        push_pixel(12'($urandom));
        push_byte({4'h0, p1[11:8]}, 0);
        push_byte(p1[7:0], 1);
        run_model();
        send_range(0, tx_q.size(), 8);
        n_total++;
        if (obs_wr.size() !== 1 || exp_wr.size() !== 1 || obs_wr[0] !== exp_wr[0])
            $display("FAIL ferr_writes got n=%0d first=%h want n=1 first=%h", obs_wr.size(),
                     obs_wr.size() > 0 ? obs_wr[0] : 29'h0, exp_wr[0]);
        else n_pass++;
        n_total++;
        if (n_err !== exp_err || n_done !== 0 || busy !== 1'b0 || n_bad !== 0)
            $display("FAIL ferr_status got err=%0d done=%0d busy=%b want err=%0d done=0 busy=0", n_err, n_done, busy, exp_err);
        else n_pass++;
    endtask

    task automatic test_bad_nibble();
        clear_all();
        push_byte(8'h00, 0); push_byte(8'h0A, 0);
        push_pixel(12'($urandom));
        push_byte(8'h3F, 0);
        push_byte(8'h00, 0); push_byte(8'h0A, 0);
        for (int k = 0; k < NUM; k++) push_pixel(12'($urandom));
        run_model();
        send_range(0, tx_q.size(), 8);
        n_total++;
        if (obs_wr.size() !== exp_wr.size()) $display("FAIL nibble_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size());
        else n_pass++;
        foreach (exp_wr[k]) if (k < obs_wr.size()) begin
            n_total++;
            if (obs_wr[k] !== exp_wr[k]) $display("FAIL nibble_wr%0d got %h want %h", k, obs_wr[k], exp_wr[k]);
            else n_pass++;
        end
        n_total++;
        if (n_err !== exp_err || n_done !== exp_done || busy !== exp_busy || n_bad !== 0)
            $display("FAIL nibble_status got err=%0d done=%0d busy=%b want err=%0d done=%0d busy=%b",
                     n_err, n_done, busy, exp_err, exp_done, exp_busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        clear_all();
        push_byte(8'h00, 0); push_byte(8'h0A, 0);
        push_pixel(12'($urandom));
        run_model();
        send_range(0, tx_q.size(), 4);
        repeat (TIMEOUT - 150) @(negedge clk);
        n_total++;
        if (n_err !== 0 || busy !== exp_busy) $display("FAIL timeout_early got err=%0d busy=%b want err=0 busy=%b", n_err, busy, exp_busy);
        else n_pass++;
        repeat (300) @(negedge clk);
        n_total++;
        if (n_err !== exp_err + 1 || busy !== 1'b0 || n_bad !== 0)
            $display("FAIL timeout_error got err=%0d busy=%b want err=%0d busy=0", n_err, busy, exp_err + 1);
        else n_pass++;
        n_total++;
        if (dut.state !== HUNT || obs_wr.size() !== exp_wr.size())
            $display("FAIL timeout_state got state=%0d writes=%0d want state=%0d writes=%0d",
                     dut.state, obs_wr.size(), HUNT, exp_wr.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        clear_all();
        push_byte(8'h00, 0); push_byte(8'h0A, 0);
        push_pixel(12'($urandom)); push_pixel(12'($urandom));
        run_model();
        send_range(0, tx_q.size(), 4);
        uart_in = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({wr_en, wr_address, wr_data, frame_done, frame_error, busy} !== 33'd0)
            $display("FAIL midreset_outputs got %h want 0", {wr_en, wr_address, wr_data, frame_done, frame_error, busy});
        else n_pass++;
        uart_in = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_total++;
        if (obs_wr.size() !== exp_wr.size() || n_done !== 0 || n_err !== 0 || busy !== 1'b0)
            $display("FAIL midreset_status got wr=%0d done=%0d err=%0d busy=%b want wr=%0d done=0 err=0 busy=0",
                     obs_wr.size(), n_done, n_err, busy, exp_wr.size());
        else n_pass++;
        n_rxv = 0;
        uart_in = 1'b0;
        repeat (3) @(negedge clk);
        uart_in = 1'b1;
        repeat (15 * CPB) @(negedge clk);
        n_total++;
        if (n_rxv !== 0) $display("FAIL glitch_byte got %0d rx events want 0", n_rxv);
        else n_pass++;
        clear_all();
        push_byte(8'h00, 0); push_byte(8'h0A, 0);
        for (int k = 0; k < NUM; k++) push_pixel(12'($urandom));
        run_model();
        send_range(0, tx_q.size(), 8);
        n_total++;
        if (obs_wr.size() !== exp_wr.size()) $display("FAIL after_reset_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size());
        else n_pass++;
        foreach (exp_wr[k]) if (k < obs_wr.size()) begin
            n_total++;
            if (obs_wr[k] !== exp_wr[k]) $display("FAIL after_reset_wr%0d got %h want %h", k, obs_wr[k], exp_wr[k]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        for (int f = 0; f < 2; f++) begin
            push_byte(8'h00, 0); push_byte(8'h0A, 0);
            for (int k = 0; k < NUM; k++) push_pixel(12'($urandom));
        end
        run_model();
        send_range(0, tx_q.size(), 0);
        n_total++;
        if (obs_wr.size() !== exp_wr.size()) $display("FAIL b2b_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size());
        else n_pass++;
        foreach (exp_wr[k]) if (k < obs_wr.size()) begin
            n_total++;
            if (obs_wr[k] !== exp_wr[k]) $display("FAIL b2b_wr%0d got %h want %h", k, obs_wr[k], exp_wr[k]);
            else n_pass++;
        end
        n_total++;
        if (n_done !== exp_done || n_err !== exp_err || n_bad !== 0)
            $display("FAIL b2b_status got done=%0d err=%0d bad=%0d want done=%0d err=%0d", n_done, n_err, n_bad, exp_done, exp_err);
        else n_pass++;
    endtask

    task automatic test_random_streams();
        for (int it = 0; it < 4; it++) begin
            clear_all();
            repeat ($urandom_range(0, 4)) push_byte(8'($urandom), $urandom_range(0, 7) == 0);
            push_byte(8'h00, 0); push_byte(8'h0A, 0);
            for (int k = 0; k < NUM; k++) begin
                logic [11:0] p;
                p = 12'($urandom);
                if ($urandom_range(0, 15) == 0) push_byte({4'($urandom_range(1, 15)), p[11:8]}, 0);
                else push_byte({4'h0, p[11:8]}, $urandom_range(0, 15) == 0);
                push_byte(p[7:0], $urandom_range(0, 15) == 0);
            end
            run_model();
            send_range(0, tx_q.size(), 12);
            if (exp_busy) begin
                repeat (TIMEOUT + 100) @(negedge clk);
                exp_err++;
            end
            n_total++;
            if (obs_wr.size() !== exp_wr.size()) $display("FAIL rand%0d_wr_count got %0d want %0d", it, obs_wr.size(), exp_wr.size());
            else n_pass++;
            foreach (exp_wr[k]) if (k < obs_wr.size()) begin
                n_total++;
                if (obs_wr[k] !== exp_wr[k]) $display("FAIL rand%0d_wr%0d got %h want %h", it, k, obs_wr[k], exp_wr[k]);
                else n_pass++;
            end
            n_total++;
            if (n_done !== exp_done || n_err !== exp_err || busy !== 1'b0 || n_bad !== 0)
                $display("FAIL rand%0d_status got done=%0d err=%0d busy=%b want done=%0d err=%0d busy=0",
                         it, n_done, n_err, busy, exp_done, exp_err);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_leading_garbage();
        test_framing_error();
        test_bad_nibble();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_streams();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/image_receiver.md
# image_receiver

Receiving end of the camera-image UART link. Deserialises the 8N1 byte stream produced by the image sender (start word, then one frame of 12-bit pixels), reassembles pixels, and emits one-cycle write strobes with address and data for a frame buffer port. Sits between a GPIO UART input pin and a 320x240 RGB444 frame buffer, all on `CLOCK_50`.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate; `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE`, truncated (434).
- `NUM_PIXELS`, 76800: pixels per frame, excluding the start word.
- `TIMEOUT_CYCLES`, 250_000: maximum idle clocks between bytes inside a frame.

Ports:
- `clk`: in, 1. System clock.
- `rst_n`: in, 1. Asynchronous, active-low reset.
- `uart_in`: in, 1. Asynchronous serial line; idles high.
- `wr_en`: out, 1. One-cycle pixel write strobe.
- `wr_address`: out, 17. Frame-buffer address, 0..`NUM_PIXELS`-1.
- `wr_data`: out, 12. Pixel, RGB444.
- `frame_done`: out, 1. One-cycle pulse when the last pixel of a frame is written.
- `frame_error`: out, 1. One-cycle pulse when a frame is aborted.
- `busy`: out, 1. High from start-word match until done or abort.

## Operation
- Wire format:
  - Each 12-bit word is two bytes, high byte first: `{4'h0, w[11:8]}`, then `w[7:0]`.
  - A frame is the start word `12'h00A`, then `NUM_PIXELS` pixel words in address order.
- UART RX (sub-module):
  - `uart_in` passes through a 2-FF synchroniser.
  - A falling edge in idle starts a bit counter. The start bit is re-checked at `CLKS_PER_BIT/2`; if it is high, the edge is a glitch and RX returns to idle with no byte.
  - Data bits are sampled LSB first at the middle of each bit.
  - The stop bit must sample 1. Otherwise RX pulses `rx_ferr` and does not pulse `rx_valid`.
- Frame FSM states:
  - `HUNT`: shift in bytes; on the consecutive pair `8'h00`, `8'h0A`, go to `PIX_HI`, set pixel counter to 0 and raise `busy`.
  - `PIX_HI`: accept a byte.
    - Bits [7:4] must be 0, else abort.
    - Store the nibble and go to `PIX_LO`.
  - `PIX_LO`: accept a byte.
    - Assert `wr_en` with `wr_data = {nibble, byte}` and `wr_address = counter`.
    - If `counter == NUM_PIXELS-1`, pulse `frame_done` and go to `HUNT`.
    - Otherwise increment the counter and go to `PIX_HI`.
- Abort (any non-`HUNT` state) is triggered by any of:
  - `rx_ferr`;
  - a bad high nibble;
  - the idle counter reaching `TIMEOUT_CYCLES`. The idle counter clears on every `rx_valid` and counts only while `busy`.
- Abort action: pulse `frame_error`, drop `busy`, go to `HUNT`. Pixels already written stay written.
- In `HUNT`, a framing error just clears the pair matcher.

## Timing
- Reset values: all outputs 0; FSM in `HUNT`; RX idle; synchroniser flops reset to 1.
- `rx_valid` is a one-cycle pulse, registered, on the cycle after the mid-stop-bit sample.
- `wr_en`, `wr_address`, `wr_data` and `frame_done` are registered: they are valid the cycle after the low byte's `rx_valid`. `wr_address` and `wr_data` hold until the next write.
- `frame_done` coincides with the final `wr_en`. `busy` falls on the same cycle.
- `frame_error` is asserted the cycle after the abort cause; `busy` falls on the same cycle.
- Throughput: one byte per 10 bit times. There is no backpressure; the consumer must accept `wr_en` every cycle it is asserted.
- Reset asserted mid-byte or mid-frame: immediate return to reset state. No `frame_done` or `frame_error` is produced.
- A start word arriving while `busy` is treated as pixel data; there is no resync inside a frame except via abort.
- Counter width is 17 bits. `NUM_PIXELS` ≤ 131072 is a parameter constraint.

## Structure
- Package `image_link_pkg`:
  - `START_WORD = 12'h00A`;
  - default `NUM_PIXELS`, `BAUD_RATE`, `CLK_FREQ`;
  - `pixel_t` (logic [11:0]) and `addr_t` (logic [16:0]);
  - FSM enum `rx_state_t` {`HUNT`, `PIX_HI`, `PIX_LO`}.
- The image sender is to import the same package so both ends share the constants.
- Sub-module `uart_rx`:
  - parameter `CLKS_PER_BIT`;
  - ports `clk`, `rst_n`, `rx`, `rx_data[7:0]`, `rx_valid`, `rx_ferr`.
- The frame FSM, idle timer and pixel counter live in `image_receiver`.

## Test plan
Bench settings: `CLKS_PER_BIT = 8`, `NUM_PIXELS = 4`, `TIMEOUT_CYCLES = 400`, unless stated.
- Nominal frame: send bytes 00 0A, 0F FF, 01 23, 0A BC, 00 00 -> four `wr_en` at addresses 0..3 with data FFF, 123, ABC, 000; `frame_done` on the 4th; `busy` low afterwards.
- Leading garbage: send 55 00 12 00 0A, then 4 pixels -> no writes before the match; the frame is received normally.
- Framing error: the 2nd pixel's low byte has stop bit 0 -> one write at address 0, then `frame_error`; `busy` low; no `frame_done`.
- Bad nibble: pixel high byte 0x3F -> `frame_error`, no write for that pixel; a following complete frame is received at addresses 0..3.
- Timeout: send start word and one pixel, then idle 400 clocks -> `frame_error` exactly once; FSM back in `HUNT`.
- Reset mid-frame: pulse `rst_n` low after 2 pixels -> all outputs 0 immediately; a subsequent full frame writes addresses 0..3 correctly. Also check a 3-clock low glitch on idle `uart_in` produces no byte.
